// File: rtl/or_gate.sv
// Bitwise OR with registered copy, activity flag and optional edge/duty stats.
// Stats (rise, fall, hi_cnt) are built only when OR_GATE_STATS_EN is defined.
module or_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  input  logic             clr,
  output logic [WIDTH-1:0] Y_q,
  output logic             any_q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] hi_cnt
);

  assign Y = A | B;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q   <= '0;
      any_q <= 1'b0;
    end else begin
      Y_q   <= Y;
      any_q <= |Y;
    end
  end

`ifdef OR_GATE_STATS_EN
  logic any_prev;

  // any_prev trails any_q so edges show one cycle after any_q moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_prev <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      hi_cnt   <= '0;
    end else begin
      any_prev <= any_q;
      if (clr) begin
        rise   <= 1'b0;
        fall   <= 1'b0;
        hi_cnt <= '0;
      end else begin
        rise <= any_q & ~any_prev;
        fall <= ~any_q & any_prev;
        if (any_q && (hi_cnt != {CNT_W{1'b1}}))
          hi_cnt <= hi_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign rise       = 1'b0;
  assign fall       = 1'b0;
  assign hi_cnt     = '0;
`endif

endmodule

// File: tb/tb_or_gate.sv
// Directed bench for or_gate: combinational sweep, registered path,
// saturation, clear, fall edge and async reset.
module tb_or_gate;

`ifdef OR_GATE_STATS_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [0:0] a = '0;
  logic [0:0] b = '0;
  logic [0:0] y, y_q;
  logic       any_q, rise, fall;
  logic [3:0] hi_cnt;

  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] y4, y4_q;
  logic       any4, rise4, fall4;
  logic [3:0] cnt4;

  int n_cmp = 0;
  int n_err = 0;

  or_gate #(.WIDTH(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Y(y), .clr(clr),
    .Y_q(y_q), .any_q(any_q), .rise(rise), .fall(fall),
    .hi_cnt(hi_cnt)
  );

  or_gate #(.WIDTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Y(y4), .clr(clr),
    .Y_q(y4_q), .any_q(any4), .rise(rise4), .fall(fall4),
    .hi_cnt(cnt4)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stats(input string tag, input logic r,
                       input logic f, input logic [3:0] c);
    chk({tag, "_rise"}, 32'(rise), 32'(r & S));
    chk({tag, "_fall"}, 32'(fall), 32'(f & S));
    chk({tag, "_cnt"}, 32'(hi_cnt), S ? 32'(c) : 32'd0);
  endtask

  initial begin
    // combinational sweep, clock idle, reset held
    a = 1'b0; b = 1'b0; #10; chk("y00", 32'(y), 32'd0);
    a = 1'b0; b = 1'b1; #10; chk("y01", 32'(y), 32'd1);
    a = 1'b1; b = 1'b0; #10; chk("y10", 32'(y), 32'd1);
    a = 1'b1; b = 1'b1; #10; chk("y11", 32'(y), 32'd1);
    chk("rst_yq", 32'(y_q), 32'd0);
    chk("rst_any", 32'(any_q), 32'd0);
    stats("rst", 1'b0, 1'b0, 4'd0);
    a4 = 4'b1010; b4 = 4'b0101; #10; chk("y4_a", 32'(y4), 32'hf);
    a4 = 4'b0000; b4 = 4'b0100; #10; chk("y4_b", 32'(y4), 32'h4);

    // registered path
    a = 1'b0; b = 1'b0;
    clk_en = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rel_yq", 32'(y_q), 32'd0);
    chk("rel_any", 32'(any_q), 32'd0);
    chk("w4_any", 32'(any4), 32'd1);
    chk("w4_yq", 32'(y4_q), 32'h4);
    a = 1'b1;
    @(negedge clk);
    chk("reg_yq", 32'(y_q), 32'd1);
    chk("reg_any", 32'(any_q), 32'd1);
    stats("reg1", 1'b0, 1'b0, 4'd0);
    @(negedge clk); stats("reg2", 1'b1, 1'b0, 4'd1);
    @(negedge clk); stats("reg3", 1'b0, 1'b0, 4'd2);

    // saturation
    repeat (20) @(negedge clk);
    stats("sat", 1'b0, 1'b0, 4'd15);
    repeat (3) @(negedge clk);
    stats("sat_hold", 1'b0, 1'b0, 4'd15);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    stats("clr", 1'b0, 1'b0, 4'd0);
    chk("clr_any", 32'(any_q), 32'd1);
    chk("clr_yq", 32'(y_q), 32'd1);
    @(negedge clk); stats("clr_next", 1'b0, 1'b0, 4'd1);

    // fall edge
    a = 1'b0;
    @(negedge clk);
    chk("fall_any", 32'(any_q), 32'd0);
    chk("fall_yq", 32'(y_q), 32'd0);
    stats("fall1", 1'b0, 1'b0, 4'd2);
    @(negedge clk); stats("fall2", 1'b0, 1'b1, 4'd2);
    @(negedge clk); stats("fall3", 1'b0, 1'b0, 4'd2);

    // async reset mid-count
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    a = 1'b1;
    @(negedge clk); chk("ar_any", 32'(any_q), 32'd1);
    repeat (7) @(negedge clk);
    stats("ar_pre", 1'b0, 1'b0, 4'd7);
    #2; rst = 1'b1; #1;
    chk("ar_yq", 32'(y_q), 32'd0);
    chk("ar_anyq", 32'(any_q), 32'd0);
    stats("ar", 1'b0, 1'b0, 4'd0);
    chk("ar_y1", 32'(y), 32'd1);
    a = 1'b0; b = 1'b1; #1; chk("ar_y2", 32'(y), 32'd1);
    b = 1'b0; #1; chk("ar_y3", 32'(y), 32'd0);
    a = 1'b1;
    @(negedge clk);
    stats("ar_hold", 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_any", 32'(any_q), 32'd1);
    stats("rs1", 1'b0, 1'b0, 4'd0);
    @(negedge clk); stats("rs2", 1'b1, 1'b0, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/or_gate.md
OR_GATE -- requirements
Module: or_gate

Interface
REQ-001 Parameter WIDTH, default 1, bit width of operands A, B and result Y.
REQ-002 Parameter CNT_W, default 16, width of the high-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 Y  output  WIDTH  combinational bitwise OR of A and B.
REQ-008 clr  input  1  synchronous clear of the statistics state; internally treated as 0 when left unconnected or driven 0.
REQ-009 Y_q  output  WIDTH  registered copy of Y.
REQ-010 any_q  output  1  registered reduction-OR of Y.
REQ-011 rise  output  1  one-cycle pulse when any_q goes 0->1.
REQ-012 fall  output  1  one-cycle pulse when any_q goes 1->0.
REQ-013 hi_cnt  output  CNT_W  number of cycles with any_q=1 since reset/clear, saturating.

Function
REQ-014 Y SHALL equal A | B bitwise at all times, with zero clock latency.
REQ-015 Y SHALL be independent of clk, rst and clr, and SHALL be correct with clk and rst unconnected or X.
REQ-016 Truth table per bit: 0,0->0; 0,1->1; 1,0->1; 1,1->1.
REQ-017 Y_q SHALL equal Y sampled at the previous rising clk edge (1-cycle latency).
REQ-018 any_q SHALL equal |Y sampled at the previous rising clk edge.
REQ-019 rise SHALL be 1 for exactly the cycle after any_q changes 0->1, and fall for exactly the cycle after any_q changes 1->0; they SHALL never both be 1.
REQ-020 hi_cnt SHALL increment by 1 on each rising edge where any_q=1; at all-ones it SHALL hold (saturate), never wrap.
REQ-021 clr=1 at a rising edge SHALL zero hi_cnt, rise and fall. Y_q and any_q SHALL still load normally. clr SHALL take priority over increment in the same cycle.
REQ-022 With WIDTH>1, any_q and the counter SHALL use the reduction-OR of all Y bits.

Reset
REQ-023 While rst=1, Y_q=0, any_q=0, rise=0, fall=0 and hi_cnt=0 SHALL hold immediately, without waiting for a clock edge.
REQ-024 Y SHALL remain A|B during reset.
REQ-025 On rst deassertion, the first rising edge SHALL load Y_q and any_q. rise SHALL assert one cycle later if |Y was 1.
REQ-026 Reset asserted mid-count SHALL discard the count. Counting SHALL restart from 0 after release.

Configuration
REQ-027 Macro OR_GATE_STATS_EN: when defined, rise, fall and hi_cnt logic SHALL be compiled in as specified.
REQ-028 When OR_GATE_STATS_EN is undefined, rise, fall and hi_cnt SHALL be tied to constant 0 and no counter or edge registers SHALL exist. Y, Y_q and any_q SHALL be unaffected.

Verification
REQ-029 Combinational sweep with WIDTH=1 and clk/rst idle, 10 ns per step: (A,B)=(0,0)->Y=0; (0,1)->Y=1; (1,0)->Y=1; (1,1)->Y=1.
REQ-030 Registered path: A=1, B=0 applied after reset release -> Y_q=1, any_q=1 after 1 edge, and rise=1 for one cycle on the following edge.
REQ-031 Saturation with CNT_W=4 and Y held 1 for 20 cycles -> hi_cnt reaches 15 and stays 15. Then clr=1 -> hi_cnt=0 on the next edge.
REQ-032 Async reset: rst asserted between clock edges while hi_cnt=7 -> all registered outputs 0 immediately, while Y still tracks A|B.
REQ-033 Fall edge: Y goes 1->0 -> any_q=0 after 1 edge, fall=1 for exactly one cycle, and hi_cnt stops incrementing.
REQ-034 Build without OR_GATE_STATS_EN and repeat REQ-030 -> rise, fall and hi_cnt stay 0, while Y_q and any_q are unchanged from REQ-030.
